// File: rtl/pipeline_cia_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_cia_subtractor_if
// Description : Operand/result valid-ready bundle for pipeline_cia_subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_cia_subtractor_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_cia_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_cia_subtractor
// Description : Three-stage carry-increment subtractor, diff = a - b - bin,
//               valid/ready on both sides. Define PIPE_SUB_OVF_EN to build
//               the signed-overflow output; otherwise ovf is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_cia_subtractor #(
  parameter int WIDTH  = 64,
  parameter int S1_NIB = 6,
  parameter int S2_NIB = 6
) (
  input  logic                          clk,
  input  logic                          rst_n,
  pipeline_cia_subtractor_if.slave      sub
);

  localparam int C_NIB = WIDTH / 4;
  localparam int C_W1  = 4 * S1_NIB;
  localparam int C_W2  = 4 * (S1_NIB + S2_NIB);

  logic                  r1_v, r2_v, r3_v;
  logic [C_W1-1:0]       r1_d;
  logic                  r1_c;
  logic [WIDTH-1:C_W1]   r1_a, r1_nb;
  logic [C_W2-1:0]       r2_d;
  logic                  r2_c;
  logic [WIDTH-1:C_W2]   r2_a, r2_nb;
  logic [WIDTH-1:0]      r3_d;
  logic                  r3_bo;

  logic                  w_stall;
  logic                  w_acc;
  logic [WIDTH-1:0]      w_x, w_y, w_sum;
  logic                  w_co1, w_co2, w_co3;

  assign w_stall       = r3_v && !sub.out_ready;
  assign sub.in_ready  = rst_n && !w_stall;
  assign w_acc         = sub.in_valid && sub.in_ready;

  // Each slice of the chain reads its operands from the stage that evaluates it.
  assign w_x = {r2_a[WIDTH-1:C_W2], r1_a[C_W2-1:C_W1], sub.a[C_W1-1:0]};
  assign w_y = {r2_nb[WIDTH-1:C_W2], r1_nb[C_W2-1:C_W1], ~sub.b[C_W1-1:0]};

  always_comb begin : p_cia
    logic [4:0] v_p;
    logic       v_c;
    v_p   = '0;
    v_c   = 1'b0;
    w_sum = '0;
    w_co1 = 1'b0;
    w_co2 = 1'b0;
    for (int i = 0; i < C_NIB; i++) begin
      if (i == 0) begin
        v_c = ~sub.bin;
      end else if (i == S1_NIB) begin
        w_co1 = v_c;
        v_c   = r1_c;
      end else if (i == S1_NIB + S2_NIB) begin
        w_co2 = v_c;
        v_c   = r2_c;
      end
      // Block sum is formed for carry-in 0, then incremented by the arriving carry.
      v_p             = {1'b0, w_x[4*i +: 4]} + {1'b0, w_y[4*i +: 4]};
      w_sum[4*i +: 4] = v_p[3:0] + {3'b000, v_c};
      v_c             = v_p[4] | (v_c & (v_p[3:0] == 4'hF));
    end
    w_co3 = v_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_v  <= 1'b0;
      r1_d  <= '0;
      r1_c  <= 1'b0;
      r1_a  <= '0;
      r1_nb <= '0;
      r2_v  <= 1'b0;
      r2_d  <= '0;
      r2_c  <= 1'b0;
      r2_a  <= '0;
      r2_nb <= '0;
      r3_v  <= 1'b0;
      r3_d  <= '0;
      r3_bo <= 1'b0;
    end else if (!w_stall) begin
      r1_v  <= w_acc;
      r1_d  <= w_sum[C_W1-1:0];
      r1_c  <= w_co1;
      r1_a  <= sub.a[WIDTH-1:C_W1];
      r1_nb <= ~sub.b[WIDTH-1:C_W1];
      r2_v  <= r1_v;
      r2_d  <= {w_sum[C_W2-1:C_W1], r1_d};
      r2_c  <= w_co2;
      r2_a  <= r1_a[WIDTH-1:C_W2];
      r2_nb <= r1_nb[WIDTH-1:C_W2];
      r3_v  <= r2_v;
      r3_d  <= {w_sum[WIDTH-1:C_W2], r2_d};
      r3_bo <= ~w_co3;
    end
  end

  assign sub.out_valid = r3_v;
  assign sub.diff      = r3_d;
  assign sub.bout      = r3_bo;

`ifdef PIPE_SUB_OVF_EN
  logic r3_ovf;
  logic w_ovf;

  // Operand signs differ when a's MSB equals the inverted subtrahend's MSB.
  assign w_ovf = (r2_a[WIDTH-1] == r2_nb[WIDTH-1]) && (w_sum[WIDTH-1] != r2_a[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r3_ovf <= 1'b0;
    end else if (!w_stall) begin
      r3_ovf <= w_ovf;
    end
  end

  assign sub.ovf = r3_ovf;
`else
  assign sub.ovf = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_cia_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_cia_subtractor
// Description : Scoreboard bench for pipeline_cia_subtractor (64-bit, 6/6 split).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_cia_subtractor;

  localparam int W = 64;
`ifdef PIPE_SUB_OVF_EN
  localparam bit C_OVF_ON = 1'b1;
`else
  localparam bit C_OVF_ON = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipeline_cia_subtractor_if #(.WIDTH(W)) sub ();

  pipeline_cia_subtractor #(
    .WIDTH  (W),
    .S1_NIB (6),
    .S2_NIB (6)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sub   (sub)
  );

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   stalls = 0;
  exp_t q[$];
  int   qc[$];
  int   qs[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain wide arithmetic; overflow when the true signed result leaves W-bit range.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    exp_t        e;
    logic [W:0]  u;
    logic [W+1:0] s;
    u    = {1'b0, a} - {1'b0, b} - (W+1)'(bin);
    e.d  = u[W-1:0];
    e.bo = u[W];
    s    = {a[W-1], a[W-1], a} - {b[W-1], b[W-1], b} - (W+2)'(bin);
    e.ov = C_OVF_ON && !((s[W+1:W-1] == 3'b000) || (s[W+1:W-1] == 3'b111));
    return e;
  endfunction

  // Monitor: acceptance pushes the model result, delivery pops and compares.
  logic         held_v = 1'b0;
  logic [W-1:0] held_d = '0;
  exp_t         m_e;
  int           m_c, m_s;

  always @(negedge clk) begin
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      chk1("in_ready", sub.in_ready, !(sub.out_valid && !sub.out_ready));
      if (held_v) begin
        chk1("stall_valid", sub.out_valid, 1'b1);
        chk("stall_diff", sub.diff, held_d);
      end
      if (sub.in_valid && sub.in_ready) begin
        q.push_back(model(sub.a, sub.b, sub.bin));
        qc.push_back(cyc);
        qs.push_back(stalls);
      end
      if (sub.out_valid && sub.out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out: got diff %h with no beat outstanding, expected none", sub.diff);
        end else begin
          m_e = q.pop_front();
          m_c = qc.pop_front();
          m_s = qs.pop_front();
          chk("diff", sub.diff, m_e.d);
          chk1("bout", sub.bout, m_e.bo);
          chk1("ovf", sub.ovf, m_e.ov);
          if (m_s == stalls) chk("latency", W'(cyc - m_c), W'(3));
        end
      end
      held_v = sub.out_valid && !sub.out_ready;
      held_d = sub.diff;
      if (held_v) stalls++;
    end
  end

  task automatic directed(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic bin, input logic [W-1:0] ed, input logic ebo, input logic eov);
    sub.a        = a;
    sub.b        = b;
    sub.bin      = bin;
    sub.in_valid = 1'b1;
    @(posedge clk); #1;
    sub.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk1({nm, "_valid"}, sub.out_valid, 1'b1);
    chk({nm, "_diff"}, sub.diff, ed);
    chk1({nm, "_bout"}, sub.bout, ebo);
    chk1({nm, "_ovf"}, sub.ovf, eov);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    sub.in_valid  = 1'b0;
    sub.out_ready = 1'b1;
    for (int k = 0; k < 30 && q.size() != 0; k++) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d results outstanding expected 0", q.size());
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return {1'b0, {(W-1){1'b1}}};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    sub.in_valid  = 1'b0;
    sub.a         = '0;
    sub.b         = '0;
    sub.bin       = 1'b0;
    sub.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_valid", sub.out_valid, 1'b0);
    chk("rst_diff", sub.diff, '0);
    chk1("rst_bout", sub.bout, 1'b0);
    chk1("rst_ovf", sub.ovf, 1'b0);
    chk1("rst_in_ready", sub.in_ready, 1'b0);
    rst_n = 1'b1;
    #1;

    directed("basic", W'(64'h10), W'(64'h3), 1'b0, W'(64'hD), 1'b0, 1'b0);
    directed("ripple", '0, W'(64'h1), 1'b0, '1, 1'b1, 1'b0);
    directed("ovf", 64'h8000_0000_0000_0000, W'(64'h1), 1'b0,
             64'h7FFF_FFFF_FFFF_FFFF, 1'b0, C_OVF_ON);

    // Backpressure: 8 back-to-back beats, consumer stalls 5 cycles mid-stream.
    begin
      int  i;
      logic acc;
      i = 0;
      for (int k = 0; k < 40 && i < 8; k++) begin
        sub.out_ready = !(k >= 3 && k < 8);
        sub.in_valid  = 1'b1;
        sub.a         = W'(i + 100);
        sub.b         = W'(i);
        sub.bin       = i[0];
        @(negedge clk);
        acc = sub.in_valid && sub.in_ready;
        @(posedge clk); #1;
        if (acc) i++;
      end
      chk("bp_issued", W'(i), W'(8));
    end
    drain();

    // Borrow-in with alternating bubbles.
    for (int k = 0; k < 10; k++) begin
      sub.in_valid = (k % 2 == 0);
      sub.a        = W'(5);
      sub.b        = W'(5);
      sub.bin      = 1'b1;
      @(posedge clk); #1;
    end
    drain();

    // Reset with three beats in flight.
    for (int k = 0; k < 3; k++) begin
      sub.in_valid = 1'b1;
      sub.a        = {$urandom, $urandom};
      sub.b        = {$urandom, $urandom};
      sub.bin      = 1'(k);
      @(posedge clk); #1;
    end
    sub.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk1("midrst_valid", sub.out_valid, 1'b0);
    chk("midrst_diff", sub.diff, '0);
    chk1("midrst_in_ready", sub.in_ready, 1'b0);
    q.delete();
    qc.delete();
    qs.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    directed("postrst", W'(77), W'(7), 1'b0, W'(70), 1'b0, 1'b0);
    drain();

    // Randomized traffic with random consumer backpressure.
    for (int k = 0; k < 400; k++) begin
      sub.out_ready = ($urandom_range(0, 3) != 0);
      sub.in_valid  = ($urandom_range(0, 3) != 0);
      sub.a         = pick();
      sub.b         = pick();
      sub.bin       = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
